// File: rtl/load_store_unit.sv
// Load/store unit between the CPU datapath and a word-addressed data memory.
// Optional build macro LSU_MISALIGN_TRAP_EN: trap misaligned accesses instead of force-aligning them.
module load_store_unit #(
   parameter int unsigned AW = 12
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  op,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        rsp_valid,
   output logic [31:0] rdata,
   output logic        exc_misalign,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_in,
   output logic        dm_wren,
   input  logic [31:0] dm_out
);

   typedef enum logic {IDLE, WRITE} state_e;

   typedef enum logic [3:0] {
      OP_LB  = 4'b0000,
      OP_LH  = 4'b0001,
      OP_LW  = 4'b0010,
      OP_LBU = 4'b0100,
      OP_LHU = 4'b0101,
      OP_SB  = 4'b1000,
      OP_SH  = 4'b1001,
      OP_SW  = 4'b1010
   } op_e;

   state_e        state_q, state_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic          exc_misalign_q, exc_misalign_d;
   logic [31:0]   rdata_q, rdata_d;
   logic [AW-1:2] waddr_q, waddr_d;
   logic [31:0]   wword_q, wword_d;

   logic          accept;
   logic          trap;
   logic [7:0]    byte_lane;
   logic [15:0]   half_lane;
   logic [31:0]   merged;
   logic          unused_addr_hi;

   assign unused_addr_hi = ^addr[31:AW];

   // Half lane depends only on addr[1], so force-aligning addr[0] needs no extra logic.
   assign byte_lane = dm_out[{addr[1:0], 3'b000} +: 8];
   assign half_lane = addr[1] ? dm_out[31:16] : dm_out[15:0];

`ifdef LSU_MISALIGN_TRAP_EN
   assign trap = (((op == OP_LH) || (op == OP_LHU) || (op == OP_SH)) && addr[0]) ||
                 (((op == OP_LW) || (op == OP_SW)) && (addr[1:0] != 2'b00));
`else
   assign trap = 1'b0;
`endif

   always_comb begin
      merged = dm_out;
      if (op == OP_SB)
         merged[{addr[1:0], 3'b000} +: 8] = wdata[7:0];
      else if (addr[1])
         merged[31:16] = wdata[15:0];
      else
         merged[15:0] = wdata[15:0];
   end

   always_comb begin
      state_d        = state_q;
      rsp_valid_d    = 1'b0;
      exc_misalign_d = 1'b0;
      rdata_d        = rdata_q;
      waddr_d        = waddr_q;
      wword_d        = wword_q;
      req_ready      = (state_q == IDLE);
      accept         = req_valid && req_ready;
      dm_addr        = '0;
      dm_in          = wdata;
      dm_wren        = 1'b0;

      case (state_q)
         IDLE: begin
            dm_addr[AW-1:2] = addr[AW-1:2];
            if (accept) begin
               rsp_valid_d = 1'b1;
               if (trap) begin
                  exc_misalign_d = 1'b1;
               end else begin
                  case (op)
                     OP_LB:  rdata_d = {{24{byte_lane[7]}}, byte_lane};
                     OP_LBU: rdata_d = {24'h0, byte_lane};
                     OP_LH:  rdata_d = {{16{half_lane[15]}}, half_lane};
                     OP_LHU: rdata_d = {16'h0, half_lane};
                     OP_LW:  rdata_d = dm_out;
                     OP_SW:  dm_wren = 1'b1;
                     OP_SB, OP_SH: begin
                        rsp_valid_d = 1'b0;
                        waddr_d     = addr[AW-1:2];
                        wword_d     = merged;
                        state_d     = WRITE;
                     end
                     default: rdata_d = '0;
                  endcase
               end
            end
         end
         WRITE: begin
            dm_addr[AW-1:2] = waddr_q;
            dm_in           = wword_q;
            dm_wren         = 1'b1;
            rsp_valid_d     = 1'b1;
            state_d         = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q        <= IDLE;
         rsp_valid_q    <= 1'b0;
         exc_misalign_q <= 1'b0;
         rdata_q        <= '0;
         waddr_q        <= '0;
         wword_q        <= '0;
      end else begin
         state_q        <= state_d;
         rsp_valid_q    <= rsp_valid_d;
         exc_misalign_q <= exc_misalign_d;
         rdata_q        <= rdata_d;
         waddr_q        <= waddr_d;
         wword_q        <= wword_d;
      end
   end

   assign rsp_valid    = rsp_valid_q;
   assign rdata        = rdata_q;
   assign exc_misalign = exc_misalign_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 1024 x 32 memory model (async read, sync write).
module tb_load_store_unit;

   logic        clock;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  op;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        rsp_valid;
   logic [31:0] rdata;
   logic        exc_misalign;
   logic [31:0] dm_addr;
   logic [31:0] dm_in;
   logic        dm_wren;
   logic [31:0] dm_out;

   logic [31:0] mem [1024];
   logic        pre_we;
   logic [9:0]  pre_idx;
   logic [31:0] pre_data;

   int checks;
   int errors;

   load_store_unit #(.AW(12)) dut (
      .clock        (clock),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .op           (op),
      .addr         (addr),
      .wdata        (wdata),
      .rsp_valid    (rsp_valid),
      .rdata        (rdata),
      .exc_misalign (exc_misalign),
      .dm_addr      (dm_addr),
      .dm_in        (dm_in),
      .dm_wren      (dm_wren),
      .dm_out       (dm_out)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   assign dm_out = mem[dm_addr[11:2]];

   always @(posedge clock) begin
      if (dm_wren)
         mem[dm_addr[11:2]] <= dm_in;
      else if (pre_we)
         mem[pre_idx] <= pre_data;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic req(input logic v, input logic [3:0] o, input logic [31:0] a, input logic [31:0] d);
      req_valid = v;
      op        = o;
      addr      = a;
      wdata     = d;
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      reset     = 1'b1;
      pre_we    = 1'b0;
      pre_idx   = '0;
      pre_data  = '0;
      req(1'b0, 4'b0000, 32'h0, 32'h0);
      #1;
      check("rst_ready", {31'h0, req_ready}, 32'h1);
      check("rst_rsp", {31'h0, rsp_valid}, 32'h0);
      check("rst_rdata", rdata, 32'h0);
      check("rst_exc", {31'h0, exc_misalign}, 32'h0);
      check("rst_wren", {31'h0, dm_wren}, 32'h0);

      // preload word0 and word1 while reset holds the unit idle
      pre_we = 1'b1; pre_idx = 10'd0; pre_data = 32'h8899AABB;
      cyc();
      pre_idx = 10'd1; pre_data = 32'h11223344;
      cyc();
      pre_we = 1'b0;
      reset  = 1'b0;
      #1;
      check("post_rst_ready", {31'h0, req_ready}, 32'h1);

      // sub-word loads from word0
      req(1'b1, 4'b0000, 32'h1, 32'h0);
      cyc();
      check("lb_rsp", {31'h0, rsp_valid}, 32'h1);
      check("lb_rdata", rdata, 32'hFFFFFFAA);
      req(1'b1, 4'b0100, 32'h1, 32'h0);
      cyc();
      check("lbu_rdata", rdata, 32'h000000AA);
      req(1'b1, 4'b0001, 32'h2, 32'h0);
      cyc();
      check("lh_rdata", rdata, 32'hFFFF8899);
      req(1'b1, 4'b0101, 32'h0, 32'h0);
      cyc();
      check("lhu_rdata", rdata, 32'h0000AABB);
      req(1'b0, 4'b0000, 32'h0, 32'h0);
      cyc();
      check("idle_rsp", {31'h0, rsp_valid}, 32'h0);
      check("rdata_hold", rdata, 32'h0000AABB);

      // SB read-modify-write with a second SB queued behind it
      req(1'b1, 4'b1000, 32'h6, 32'hCCCCCC55);
      #1;
      check("sb_n_wren", {31'h0, dm_wren}, 32'h0);
      check("sb_n_ready", {31'h0, req_ready}, 32'h1);
      cyc();
      check("sb_n1_ready", {31'h0, req_ready}, 32'h0);
      check("sb_n1_wren", {31'h0, dm_wren}, 32'h1);
      check("sb_n1_addr", dm_addr, 32'h4);
      check("sb_n1_din", dm_in, 32'h11553344);
      check("sb_n1_rsp", {31'h0, rsp_valid}, 32'h0);
      req(1'b1, 4'b1000, 32'h4, 32'hAAAAAA77);
      cyc();
      check("sb_n2_rsp", {31'h0, rsp_valid}, 32'h1);
      check("sb_mem1", mem[1], 32'h11553344);
      check("sb2_accept_ready", {31'h0, req_ready}, 32'h1);
      check("sb2_n_wren", {31'h0, dm_wren}, 32'h0);
      cyc();
      req(1'b0, 4'b0000, 32'h0, 32'h0);
      check("sb2_n1_ready", {31'h0, req_ready}, 32'h0);
      check("sb2_n1_din", dm_in, 32'h11553377);
      check("sb2_n1_rsp", {31'h0, rsp_valid}, 32'h0);
      cyc();
      check("sb2_rsp", {31'h0, rsp_valid}, 32'h1);
      check("sb2_mem1", mem[1], 32'h11553377);
      check("sb_rdata_hold", rdata, 32'h0000AABB);

      // SW followed by LW of the same word
      req(1'b1, 4'b1010, 32'h8, 32'hDEADBEEF);
      #1;
      check("sw_wren", {31'h0, dm_wren}, 32'h1);
      check("sw_addr", dm_addr, 32'h8);
      check("sw_din", dm_in, 32'hDEADBEEF);
      cyc();
      check("sw_rsp", {31'h0, rsp_valid}, 32'h1);
      req(1'b1, 4'b0010, 32'h8, 32'h0);
      #1;
      check("lw_wren", {31'h0, dm_wren}, 32'h0);
      cyc();
      check("lw_rsp", {31'h0, rsp_valid}, 32'h1);
      check("lw_rdata", rdata, 32'hDEADBEEF);

      // misaligned SH at address 3
      req(1'b1, 4'b1001, 32'h3, 32'h1234CAFE);
      #1;
      check("sh_n_wren", {31'h0, dm_wren}, 32'h0);
      cyc();
      req(1'b0, 4'b0000, 32'h0, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
      check("shm_rsp", {31'h0, rsp_valid}, 32'h1);
      check("shm_exc", {31'h0, exc_misalign}, 32'h1);
      check("shm_ready", {31'h0, req_ready}, 32'h1);
      check("shm_wren", {31'h0, dm_wren}, 32'h0);
      check("shm_rdata", rdata, 32'hDEADBEEF);
      cyc();
      check("shm_exc_pulse", {31'h0, exc_misalign}, 32'h0);
      check("shm_mem0", mem[0], 32'h8899AABB);
`else
      check("sha_ready", {31'h0, req_ready}, 32'h0);
      check("sha_wren", {31'h0, dm_wren}, 32'h1);
      check("sha_din", dm_in, 32'hCAFEAABB);
      check("sha_exc_n1", {31'h0, exc_misalign}, 32'h0);
      cyc();
      check("sha_rsp", {31'h0, rsp_valid}, 32'h1);
      check("sha_exc", {31'h0, exc_misalign}, 32'h0);
      check("sha_mem0", mem[0], 32'hCAFEAABB);
`endif

      // unknown op code
      req(1'b1, 4'b0011, 32'h8, 32'hFFFFFFFF);
      #1;
      check("unk_wren", {31'h0, dm_wren}, 32'h0);
      cyc();
      req(1'b0, 4'b0000, 32'h0, 32'h0);
      check("unk_rsp", {31'h0, rsp_valid}, 32'h1);
      check("unk_rdata", rdata, 32'h0);
      check("unk_mem2", mem[2], 32'hDEADBEEF);

      // reset asserted while an SB sits in WRITE
      req(1'b1, 4'b1000, 32'h8, 32'h00000011);
      cyc();
      req(1'b0, 4'b0000, 32'h0, 32'h0);
      check("rw_in_write", {31'h0, dm_wren}, 32'h1);
      reset = 1'b1;
      #1;
      check("rw_wren", {31'h0, dm_wren}, 32'h0);
      check("rw_ready", {31'h0, req_ready}, 32'h1);
      check("rw_rsp", {31'h0, rsp_valid}, 32'h0);
      cyc();
      check("rw_rsp_after", {31'h0, rsp_valid}, 32'h0);
      check("rw_mem2", mem[2], 32'hDEADBEEF);
      reset = 1'b0;
      cyc();
      check("rw_ready_after", {31'h0, req_ready}, 32'h1);
      check("rw_rsp_final", {31'h0, rsp_valid}, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
